// File: rtl/conf_int_mac_pipe_acc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conf_int_mac_pipe_acc                                      |
// | Description : Two-stage pipelined unsigned integer MAC with operand      |
// |               precision control, valid/ready streaming and multi-beat    |
// |               accumulation with sticky overflow.                         |
// |               d = ((a' * b') mod 2^N) + (c or running accumulator)       |
// |               where a', b' have their low N-P bits cleared.              |
// | Ports       : clk, rst (async, active-low)                               |
// |               in_valid/in_ready   : operand beat handshake               |
// |               a, b, c [N-1:0]     : operands / addend                    |
// |               mode, last          : 0 = single MAC, 1 = accumulate;      |
// |                                     last closes an accumulation          |
// |               out_valid/out_ready : result handshake                     |
// |               d [N-1:0], d_ovf    : result and overflow flag             |
// |               busy                : an accumulation is open              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module conf_int_mac_pipe_acc #(
   parameter int DATA_PATH_BITWIDTH = 16,
   // Legal range is 1..DATA_PATH_BITWIDTH.
   parameter int OP_BITWIDTH        = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DATA_PATH_BITWIDTH-1:0] a,
   input  logic [DATA_PATH_BITWIDTH-1:0] b,
   input  logic [DATA_PATH_BITWIDTH-1:0] c,
   input  logic                          mode,
   input  logic                          last,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DATA_PATH_BITWIDTH-1:0] d,
   output logic                          d_ovf,
   output logic                          busy
);

   localparam int c_n = DATA_PATH_BITWIDTH;

   // Keeps the top P bits of an operand; all ones when P == N.
   localparam logic [c_n-1:0] c_op_mask = {c_n{1'b1}} << (DATA_PATH_BITWIDTH - OP_BITWIDTH);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } state_t;

   // Stage 1
   logic           s1_valid_q, s1_valid_d;
   logic [c_n-1:0] s1_p_q,     s1_p_d;
   logic [c_n-1:0] s1_c_q,     s1_c_d;
   logic           s1_mode_q,  s1_mode_d;
   logic           s1_last_q,  s1_last_d;

   // Accumulation control
   state_t         state_q,      state_d;
   logic [c_n-1:0] acc_q,        acc_d;
   logic           ovf_sticky_q, ovf_sticky_d;

   // Output register
   logic           out_valid_q, out_valid_d;
   logic [c_n-1:0] d_q,         d_d;
   logic           d_ovf_q,     d_ovf_d;

   logic           w_adv;
   logic           w_in_fire;
   logic [c_n-1:0] w_am;
   logic [c_n-1:0] w_bm;
   logic [c_n-1:0] w_p;
   logic [c_n-1:0] w_addend;
   logic [c_n:0]   w_sum;
   logic           w_acc_open;

   // Stage 2 moves whenever the output register is free or being drained.
   assign w_adv     = s1_valid_q && (!out_valid_q || out_ready);
   // Held low during reset so no beat is taken while the pipe is cleared.
   assign in_ready  = rst && (!s1_valid_q || w_adv);
   assign w_in_fire = in_valid && in_ready;

   assign w_am = a & c_op_mask;
   assign w_bm = b & c_op_mask;
   // Only the low N bits of the product are kept, so an N-bit multiply suffices.
   assign w_p  = w_am * w_bm;

   // Mode-0 beats inside an open accumulation must still add c, not acc.
   assign w_acc_open = (state_q == ST_ACC);
   assign w_addend   = (s1_mode_q && w_acc_open) ? acc_q : s1_c_q;
   assign w_sum      = {1'b0, s1_p_q} + {1'b0, w_addend};

   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_p_d       = s1_p_q;
      s1_c_d       = s1_c_q;
      s1_mode_d    = s1_mode_q;
      s1_last_d    = s1_last_q;
      state_d      = state_q;
      acc_d        = acc_q;
      ovf_sticky_d = ovf_sticky_q;
      out_valid_d  = out_valid_q;
      d_d          = d_q;
      d_ovf_d      = d_ovf_q;

      // Stage 1 load / drain
      if (w_in_fire) begin
         s1_valid_d = 1'b1;
         s1_p_d     = w_p;
         s1_c_d     = c;
         s1_mode_d  = mode;
         s1_last_d  = last;
      end else if (w_adv) begin
         s1_valid_d = 1'b0;
      end

      // An output transfer frees the register unless a new result lands now.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      // Stage 2
      if (w_adv) begin
         if (!s1_mode_q) begin
            out_valid_d = 1'b1;
            d_d         = w_sum[c_n-1:0];
            d_ovf_d     = w_sum[c_n];
         end else if (s1_last_q) begin
            out_valid_d  = 1'b1;
            d_d          = w_sum[c_n-1:0];
            d_ovf_d      = w_sum[c_n] | (w_acc_open & ovf_sticky_q);
            state_d      = ST_IDLE;
            ovf_sticky_d = 1'b0;
         end else begin
            // A first beat starts a fresh sticky history.
            acc_d        = w_sum[c_n-1:0];
            state_d      = ST_ACC;
            ovf_sticky_d = (w_acc_open & ovf_sticky_q) | w_sum[c_n];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q   <= 1'b0;
         s1_p_q       <= '0;
         s1_c_q       <= '0;
         s1_mode_q    <= 1'b0;
         s1_last_q    <= 1'b0;
         state_q      <= ST_IDLE;
         acc_q        <= '0;
         ovf_sticky_q <= 1'b0;
         out_valid_q  <= 1'b0;
         d_q          <= '0;
         d_ovf_q      <= 1'b0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_p_q       <= s1_p_d;
         s1_c_q       <= s1_c_d;
         s1_mode_q    <= s1_mode_d;
         s1_last_q    <= s1_last_d;
         state_q      <= state_d;
         acc_q        <= acc_d;
         ovf_sticky_q <= ovf_sticky_d;
         out_valid_q  <= out_valid_d;
         d_q          <= d_d;
         d_ovf_q      <= d_ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign d         = d_q;
   assign d_ovf     = d_ovf_q;
   assign busy      = (state_q == ST_ACC);

endmodule
`default_nettype wire
